regfile_dump_reader: RTL and testbench

REGFILE_DUMP_READER -- requirements
Module: regfile_dump_reader

---
 rtl/regfile_dump_reader.sv | 159 +++++++++++++++
 tb/tb_regfile_dump_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_dump_reader.sv
// regfile_dump_reader
//   Walks the register file two registers at a time and streams every value
//   out over a valid/ready port. Each pair is read in one cycle through the
//   two read ports (RS = 2k, RT = 2k+1). Both words are captured into local
//   buffers, so later register writes cannot change a pair that was already
//   read. The two words are then emitted in order.
//
// Ports
//   clk, rst_n           clock, async active-low reset
//   start                begin a full dump (sampled only in IDLE)
//   abort                cancel a dump in progress (wins over a handshake)
//   RS, RT               register file read addresses (0 outside READ)
//   REGISTER_1/2         combinational read data for RS / RT
//   dout_valid/ready     output word handshake
//   dout_data/index/last register value, its number, final-word flag
//   busy                 dump in progress
//   done                 one-cycle pulse after the final word is accepted

// Per-read-port capture buffer; one instance per port.
module regfile_dump_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cap,
  input  logic [31:0] d,
  output logic [31:0] q
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n)   q <= '0;
    else if (cap) q <= d;
endmodule

module regfile_dump_reader #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  output logic [ADDR_W-1:0] RS,
  output logic [ADDR_W-1:0] RT,
  input  logic [31:0]       REGISTER_1,
  input  logic [31:0]       REGISTER_2,
  output logic              dout_valid,
  input  logic              dout_ready,
  output logic [31:0]       dout_data,
  output logic [ADDR_W-1:0] dout_index,
  output logic              dout_last,
  output logic              busy,
  output logic              done
);
  localparam int NUM_PAIRS = NUM_REGS / 2;
  localparam int KW        = ADDR_W - 1;

  typedef enum logic [1:0] {IDLE, READ, EMIT_A, EMIT_B} state_t;

  state_t             state, state_nxt;
  logic [KW-1:0]      k, k_nxt;
  logic               done_nxt;
  logic               cap;
  logic [ADDR_W-1:0]  pair_base;
  logic               last_pair;
  logic [1:0][31:0]   rd_data, buf_q;

  // Lane 0 = buffer A (RS side), lane 1 = buffer B (RT side).
  assign rd_data = {REGISTER_2, REGISTER_1};

  for (genvar g = 0; g < 2; g++) begin : g_buf
    regfile_dump_buf u_buf (
      .clk   (clk),
      .rst_n (rst_n),
      .cap   (cap),
      .d     (rd_data[g]),
      .q     (buf_q[g])
    );
  end

  assign pair_base = {k, 1'b0};
  // k stops at the terminal pair; the dump ends there instead of wrapping.
  assign last_pair = (k == KW'(NUM_PAIRS - 1));

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      k     <= '0;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      k     <= k_nxt;
      done  <= done_nxt;
    end

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    done_nxt  = 1'b0;
    cap       = 1'b0;
    case (state)
      IDLE:
        if (start) begin
          state_nxt = READ;
          k_nxt     = '0;
        end
      READ:
        if (abort) state_nxt = IDLE;
        else begin
          cap       = 1'b1;
          state_nxt = EMIT_A;
        end
      EMIT_A:
        if (abort)           state_nxt = IDLE;
        else if (dout_ready) state_nxt = EMIT_B;
      EMIT_B:
        if (abort) state_nxt = IDLE;
        else if (dout_ready) begin
          if (last_pair) begin
            state_nxt = IDLE;
            done_nxt  = 1'b1;
          end else begin
            state_nxt = READ;
            k_nxt     = k + KW'(1);
          end
        end
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decode straight from state and the held buffers, so they stay
  // stable through a stall and read as zero under reset.
  always_comb begin
    RS         = '0;
    RT         = '0;
    dout_valid = 1'b0;
    dout_data  = '0;
    dout_index = '0;
    dout_last  = 1'b0;
    case (state)
      READ: begin
        RS = pair_base;
        RT = pair_base | ADDR_W'(1);
      end
      EMIT_A: begin
        dout_valid = 1'b1;
        dout_data  = buf_q[0];
        dout_index = pair_base;
      end
      EMIT_B: begin
        dout_valid = 1'b1;
        dout_data  = buf_q[1];
        dout_index = pair_base | ADDR_W'(1);
        dout_last  = last_pair;
      end
      default: ;
    endcase
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_regfile_dump_reader.sv
module tb_regfile_dump_reader;
  localparam int NR = 32;
  localparam int AW = 5;

  logic          clk = 0, rst_n = 0, start = 0, abort = 0, dout_ready = 0;
  logic [AW-1:0] RS, RT, dout_index;
  logic [31:0]   REGISTER_1, REGISTER_2, dout_data;
  logic          dout_valid, dout_last, busy, done;
  logic [31:0]   regs [NR];

  // second instance, NUM_REGS=4
  logic          start4 = 0, abort4 = 0, ready4 = 1;
  logic [AW-1:0] RS4, RT4, index4;
  logic [31:0]   R1_4, R2_4, data4;
  logic          valid4, last4, busy4, done4;
  logic [31:0]   regs4 [NR];

  assign REGISTER_1 = regs[RS];
  assign REGISTER_2 = regs[RT];
  assign R1_4 = regs4[RS4];
  assign R2_4 = regs4[RT4];

  always #5 clk = ~clk;

  regfile_dump_reader #(.NUM_REGS(NR), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort),
    .RS(RS), .RT(RT), .REGISTER_1(REGISTER_1), .REGISTER_2(REGISTER_2),
    .dout_valid(dout_valid), .dout_ready(dout_ready), .dout_data(dout_data),
    .dout_index(dout_index), .dout_last(dout_last), .busy(busy), .done(done)
  );

  regfile_dump_reader #(.NUM_REGS(4), .ADDR_W(AW)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .abort(abort4),
    .RS(RS4), .RT(RT4), .REGISTER_1(R1_4), .REGISTER_2(R2_4),
    .dout_valid(valid4), .dout_ready(ready4), .dout_data(data4),
    .dout_index(index4), .dout_last(last4), .busy(busy4), .done(done4)
  );

  typedef struct {
    logic [AW-1:0] idx;
    logic [31:0]   data;
    logic          last;
  } exp_t;

  exp_t sb[$];
  int   checks = 0, failures = 0;
  int   cyc = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  initial forever @(posedge clk) cyc++;

  // Reference model: a dump is the register contents at the moment the
  // model decides them, in index order; the last word is NR-1.
  task automatic push_dump(input int upto);
    for (int i = 0; i <= upto; i++) begin
      exp_t e;
      e.idx  = AW'(i);
      e.data = regs[i];
      e.last = (i == NR - 1);
      sb.push_back(e);
    end
  endtask

  // Monitor: every presented word must match the queue head (which also
  // covers stability through stalls); it is consumed on an accepted
  // handshake. done is due exactly the cycle after the final word is taken.
  initial begin
    logic last_acc;
    last_acc = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) last_acc = 1'b0;
      else begin
        chk("done_pulse", done, last_acc);
        last_acc = 1'b0;
        if (dout_valid) begin
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL unexpected_word actual_index=%0d expected=none", dout_index);
          end else begin
            chk("dout_index", dout_index, sb[0].idx);
            chk("dout_data",  dout_data,  sb[0].data);
            chk("dout_last",  dout_last,  sb[0].last);
            if (dout_ready && !abort) begin
              last_acc = sb[0].last;
              void'(sb.pop_front());
            end
          end
        end else chk("last_without_valid", dout_last, 0);
      end
    end
  end

  task automatic start_pulse();
    start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_idle(input string name);
    for (int n = 0; n < 400; n++) begin
      if (!busy) return;
      @(posedge clk); #1;
    end
    checks++; failures++;
    $display("FAIL %s timeout waiting for idle", name);
  endtask

  task automatic wait_word(input int idx, input string name);
    for (int n = 0; n < 200; n++) begin
      @(posedge clk); #1;
      if (dout_valid && dout_index == AW'(idx)) return;
    end
    checks++; failures++;
    $display("FAIL %s timeout waiting for index %0d", name, idx);
  endtask

  task automatic run_dump(input string name);
    dout_ready = 1;
    push_dump(NR - 1);
    start_pulse();
    wait_idle(name);
    chk({name, "_drained"}, sb.size(), 0);
  endtask

  initial begin
    int t0, td, n4, d4;
    bit got;
    for (int i = 0; i < NR; i++) begin
      regs[i]  = 32'(i * 8);
      regs4[i] = 32'hA000 + 32'(i * 3);
    end

    // reset state
    #12;
    chk("rst_valid", dout_valid, 0);
    chk("rst_busy",  busy, 0);
    chk("rst_done",  done, 0);
    chk("rst_rs_rt", {RS, RT}, 0);
    chk("rst_data",  dout_data, 0);
    chk("rst_index", dout_index, 0);
    @(posedge clk); #1 rst_n = 1;

    // full dump, reg[i]=i*8, ready=1: latency and total length
    dout_ready = 1;
    push_dump(NR - 1);
    start_pulse();
    t0 = cyc;
    @(negedge clk);
    chk("read_rs", RS, 0);
    chk("read_rt", RT, 1);
    chk("read_no_valid", dout_valid, 0);
    @(negedge clk);
    chk("first_valid_latency", dout_valid, 1);
    got = 0;
    for (int n = 0; n < 100 && !got; n++) begin
      @(negedge clk);
      if (done) begin got = 1; td = cyc; end
    end
    chk("done_seen", got, 1);
    if (got) chk("done_48_cycles", td - t0, 48);
    @(posedge clk); #1;
    chk("idle_after_done", busy, 0);
    chk("dump1_drained", sb.size(), 0);

    // random data, random backpressure
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    push_dump(NR - 1);
    start = 1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk); #1;
      start = 0;
      dout_ready = 1'($urandom_range(0, 1));
      if (!busy && sb.size() == 0) break;
    end
    chk("random_ready_drained", sb.size(), 0);
    chk("random_ready_idle", busy, 0);

    // snapshot: write reg 3 one cycle after the (2,3) read
    dout_ready = 1;
    for (int i = 0; i < NR; i++) regs[i] = $urandom;
    push_dump(NR - 1);
    start_pulse();
    got = 0;
    for (int n = 0; n < 50 && !got; n++) begin
      if (busy && RS == 2 && RT == 3) got = 1;
      else begin @(posedge clk); #1; end
    end
    chk("saw_pair1_read", got, 1);
    @(posedge clk); #1;
    regs[3] = 32'hDEADBEEF;
    wait_idle("snapshot");
    chk("snapshot_drained", sb.size(), 0);
    run_dump("after_write");

    // abort during EMIT_B of pair 5 with ready=1
    push_dump(11);
    start_pulse();
    wait_word(11, "abort_wait");
    abort = 1;
    @(posedge clk); #1;
    abort = 0;
    chk("abort_busy",  busy, 0);
    chk("abort_valid", dout_valid, 0);
    chk("abort_done",  done, 0);
    chk("abort_word11_not_taken", sb.size(), 1);
    sb.delete();
    @(posedge clk); #1;
    chk("abort_no_late_done", done, 0);
    run_dump("restart_after_abort");

    // reset mid-stall at index 17
    push_dump(17);
    start_pulse();
    wait_word(17, "stall_wait");
    dout_ready = 0;
    repeat (3) @(posedge clk);
    #3 rst_n = 0;
    #1;
    chk("midrst_valid", dout_valid, 0);
    chk("midrst_busy",  busy, 0);
    chk("midrst_done",  done, 0);
    chk("midrst_rs_rt", {RS, RT}, 0);
    chk("midrst_data",  dout_data, 0);
    chk("midrst_index", dout_index, 0);
    chk("midrst_last",  dout_last, 0);
    sb.delete();
    @(posedge clk); #1 rst_n = 1;
    repeat (2) @(posedge clk); #1;
    chk("post_rst_idle", busy, 0);

    // start held high through a whole dump: exactly one dump is delivered
    dout_ready = 1;
    push_dump(NR - 1);
    start = 1;
    got = 0;
    for (int n = 0; n < 200 && !got; n++) begin
      @(negedge clk);
      if (done) got = 1;
    end
    start = 0;
    chk("held_start_done", got, 1);
    chk("held_start_one_dump", sb.size(), 0);
    @(posedge clk); #1;
    chk("held_start_idle", busy, 0);

    // NUM_REGS=4 instance
    start4 = 1;
    @(posedge clk); #1;
    start4 = 0;
    t0 = cyc; n4 = 0; d4 = -1;
    for (int n = 0; n < 12; n++) begin
      @(negedge clk);
      if (valid4) begin
        chk("r4_index", index4, AW'(n4));
        chk("r4_data",  data4, regs4[n4]);
        chk("r4_last",  last4, n4 == 3);
        n4++;
      end
      if (done4) d4 = cyc - t0;
    end
    chk("r4_word_count", n4, 4);
    chk("r4_done_6_cycles", d4, 6);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout");
    $fatal(1);
  end

endmodule
